// File: rtl/vec_checker_i8.sv
// vec_checker_i8: issues a loadable vector table to a DUT and checks its responses after LATENCY cycles.
// Optional macro CHECKER_STOP_ON_FAIL_EN ends the run on the first mismatch.
module vec_checker_i8 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int LATENCY = 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_a,
    input  logic [WIDTH-1:0] wr_b,
    input  logic [WIDTH-1:0] wr_y,
    input  logic [AW:0]      count,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [AW-1:0]    fail_index
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] y;
        logic [AW-1:0]    i;
    } tag_t;

    state_t state_q, state_d;
    logic [AW-1:0] idx_q, idx_d, fi_q, fi_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [7:0] err_q, err_d;
    tag_t dl_q [LATENCY+1];
    tag_t dl_d [LATENCY+1];
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [WIDTH-1:0] mem_y [DEPTH];
    logic mism, pending;

    assign busy = state_q == ISSUE || state_q == DRAIN;
    assign done = state_q == DONE;
    assign pass = done && err_q == 8'd0;
    assign a = a_q;
    assign b = b_q;
    assign err_count = err_q;
    assign fail_index = fi_q;

    always_ff @(posedge clock) begin
        if (wr_en && !busy) begin
            mem_a[wr_addr] <= wr_a;
            mem_b[wr_addr] <= wr_b;
            mem_y[wr_addr] <= wr_y;
        end
    end

    // dl_q[0] is loaded alongside a/b, so dl_q[LATENCY] lines up with the DUT's y
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i <= LATENCY; i++) pending = pending | dl_q[i].v;
        mism = dl_q[LATENCY].v && y != dl_q[LATENCY].y;
        state_d = state_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
        a_d = a_q;
        b_d = b_q;
        err_d = mism ? err_q + 8'(err_q != 8'hFF) : err_q;
        fi_d = mism && err_q == 8'd0 ? dl_q[LATENCY].i : fi_q;
        dl_d[0] = '0;
        for (int i = 1; i <= LATENCY; i++) dl_d[i] = dl_q[i-1];
        case (state_q)
            IDLE, DONE: if (start) begin
                err_d = 8'd0;
                fi_d = '0;
                cnt_d = count;
                idx_d = '0;
                state_d = count == '0 ? DONE : ISSUE;
            end
            ISSUE: begin
                a_d = mem_a[idx_q];
                b_d = mem_b[idx_q];
                dl_d[0] = '{v: 1'b1, y: mem_y[idx_q], i: idx_q};
                idx_d = idx_q + 1'b1;
                state_d = {1'b0, idx_q} == cnt_q - 1'b1 ? DRAIN : ISSUE;
            end
            DRAIN: state_d = pending ? DRAIN : DONE;
            default: state_d = IDLE;
        endcase
`ifdef CHECKER_STOP_ON_FAIL_EN
        if (mism) begin
            state_d = DONE;
            a_d = a_q;
            b_d = b_q;
            for (int i = 0; i <= LATENCY; i++) dl_d[i] = '0;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q <= '0;
            cnt_q <= '0;
            a_q <= '0;
            b_q <= '0;
            err_q <= 8'd0;
            fi_q <= '0;
            for (int i = 0; i <= LATENCY; i++) dl_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            a_q <= a_d;
            b_q <= b_d;
            err_q <= err_d;
            fi_q <= fi_d;
            dl_q <= dl_d;
        end
    end
endmodule

// File: tb/tb_vec_checker_i8.sv
// tb_vec_checker_i8: runs three checkers (LATENCY 0, 1, 3) against AND DUTs from one shared stimulus stream.
module tb_vec_checker_i8;
    logic clock = 0, reset = 1, wr_en = 0, start = 0, extra = 0;
    logic [3:0] wr_addr = 0;
    logic [7:0] wr_a = 0, wr_b = 0, wr_y = 0;
    logic [4:0] count = 0;
    logic [7:0] a_w [3];
    logic [7:0] b_w [3];
    logic [7:0] y_w [3];
    logic [7:0] err_w [3];
    logic [3:0] fi_w [3];
    logic busy_w [3];
    logic done_w [3];
    logic pass_w [3];
    logic [7:0] r1;
    logic [7:0] p3 [4];
    logic [7:0] ta [16];
    logic [7:0] tbv [16];
    logic [7:0] ty [16];
    int lat [3] = '{0, 1, 3};
    int cyc [3];
    int tests = 0, fails = 0;

    typedef struct {
        int cnt;
        logic [15:0] mask;
        int e_err;
        int e_fi;
        int e_pass;
    } rec_t;
    rec_t recs [8];

    always #5 clock = ~clock;

    vec_checker_i8 #(.LATENCY(0)) u0 (.clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_a(wr_a), .wr_b(wr_b), .wr_y(wr_y), .count(count), .start(start), .a(a_w[0]), .b(b_w[0]),
        .y(y_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_w[0]),
        .fail_index(fi_w[0]));
    vec_checker_i8 #(.LATENCY(1)) u1 (.clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_a(wr_a), .wr_b(wr_b), .wr_y(wr_y), .count(count), .start(start), .a(a_w[1]), .b(b_w[1]),
        .y(y_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_w[1]),
        .fail_index(fi_w[1]));
    vec_checker_i8 #(.LATENCY(3)) u3 (.clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_a(wr_a), .wr_b(wr_b), .wr_y(wr_y), .count(count), .start(start), .a(a_w[2]), .b(b_w[2]),
        .y(y_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(err_w[2]),
        .fail_index(fi_w[2]));

    assign y_w[0] = a_w[0] & b_w[0];
    always @(posedge clock) r1 <= a_w[1] & b_w[1];
    assign y_w[1] = r1;
    always @(posedge clock) begin
        p3[0] <= a_w[2] & b_w[2];
        for (int i = 1; i < 4; i++) p3[i] <= p3[i-1];
    end
    assign y_w[2] = extra ? p3[3] : p3[2];

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic write_table();
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            wr_en = 1; wr_addr = 4'(k); wr_a = ta[k]; wr_b = tbv[k]; wr_y = ty[k];
        end
        @(negedge clock);
        wr_en = 0;
    endtask

    task automatic load_fixed(input logic [15:0] mask);
        for (int k = 0; k < 16; k++) begin
            ta[k] = (k % 2) ? 8'hF0 : 8'h03;
            tbv[k] = (k % 2) ? 8'h3C : 8'h03;
            ty[k] = mask[k] ? 8'hFF : (ta[k] & tbv[k]);
        end
        write_table();
    endtask

    // Expected outcome of a run from the table contents alone
    function automatic void model(input int cnt, input int l, output int err, output int fi, output int cy);
        err = 0; fi = 0;
        cy = cnt == 0 ? 1 : cnt + l + 2;
        for (int k = 0; k < cnt; k++) begin
            if ((ta[k] & tbv[k]) != ty[k]) begin
                if (err == 0) begin
                    fi = k;
`ifdef CHECKER_STOP_ON_FAIL_EN
                    cy = k + l + 2;
`endif
                end
                if (err < 255) err++;
            end
        end
`ifdef CHECKER_STOP_ON_FAIL_EN
        if (err > 1) err = 1;
`endif
    endfunction

    task automatic run(input int cnt);
        count = 5'(cnt);
        @(negedge clock); start = 1;
        @(negedge clock); start = 0;
        if (cnt != 0) chk("done_drop_after_start", done_w[1], 0);
        cyc = '{-1, -1, -1};
        for (int n = 1; n <= 100 && (cyc[0] < 0 || cyc[1] < 0 || cyc[2] < 0); n++) begin
            @(negedge clock);
            for (int j = 0; j < 3; j++) if (done_w[j] && cyc[j] < 0) cyc[j] = n;
        end
    endtask

    task automatic verify(input string tag, input int cnt, input int e_err, input int e_fi, input int e_pass);
        int err, fi, cy;
        for (int j = 0; j < 3; j++) begin
            model(cnt, lat[j], err, fi, cy);
            chk($sformatf("%s_L%0d_cycles", tag, lat[j]), cyc[j], cy);
            chk($sformatf("%s_L%0d_pass", tag, lat[j]), pass_w[j], e_pass);
            chk($sformatf("%s_L%0d_err", tag, lat[j]), err_w[j], e_err);
            chk($sformatf("%s_L%0d_fidx", tag, lat[j]), fi_w[j], e_fi);
        end
    endtask

    initial begin
        int err, fi, cy, cnt, n;
        logic [7:0] a_prev;
        recs[0] = '{4, 16'h0000, 0, 0, 1};
        recs[1] = '{4, 16'h0004, 1, 2, 0};
        recs[2] = '{0, 16'h0000, 0, 0, 1};
        recs[3] = '{16, 16'h0000, 0, 0, 1};
        recs[4] = '{16, 16'h8001, 2, 0, 0};
        recs[5] = '{3, 16'h0008, 0, 0, 1};
        recs[6] = '{16, 16'hFFFF, 16, 0, 0};
        recs[7] = '{1, 16'h0001, 1, 0, 0};

        #1 reset = 0;
        #20;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("rst_a_%0d", j), a_w[j], 0);
            chk($sformatf("rst_b_%0d", j), b_w[j], 0);
            chk($sformatf("rst_busy_%0d", j), busy_w[j], 0);
            chk($sformatf("rst_done_%0d", j), done_w[j], 0);
            chk($sformatf("rst_pass_%0d", j), pass_w[j], 0);
            chk($sformatf("rst_err_%0d", j), err_w[j], 0);
            chk($sformatf("rst_fidx_%0d", j), fi_w[j], 0);
        end
        @(negedge clock); reset = 1;

        for (int i = 0; i < 8; i++) begin
            load_fixed(recs[i].mask);
            a_prev = a_w[1];
            run(recs[i].cnt);
`ifdef CHECKER_STOP_ON_FAIL_EN
            verify($sformatf("rec%0d", i), recs[i].cnt, recs[i].e_err > 0 ? 1 : 0, recs[i].e_fi, recs[i].e_pass);
`else
            verify($sformatf("rec%0d", i), recs[i].cnt, recs[i].e_err, recs[i].e_fi, recs[i].e_pass);
`endif
            if (recs[i].cnt == 0) chk("zero_count_a_held", a_w[1], a_prev);
        end

        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 16; k++) begin
                ta[k] = 8'($urandom);
                tbv[k] = 8'($urandom);
                ty[k] = ($urandom_range(3) == 0) ? 8'($urandom) : (ta[k] & tbv[k]);
            end
            write_table();
            cnt = $urandom_range(16);
            run(cnt);
            model(cnt, 1, err, fi, cy);
            verify($sformatf("rand%0d", r), cnt, err, fi, err == 0 ? 1 : 0);
        end

        load_fixed(16'h0000);
        extra = 1;
        run(16);
        chk("late_dut_err_ge1", err_w[2] >= 8'd1 ? 1 : 0, 1);
        chk("late_dut_pass", pass_w[2], 0);
        chk("timely_dut_pass", pass_w[1], 1);
        extra = 0;

        count = 16;
        @(negedge clock); start = 1;
        @(negedge clock); start = 0;
        repeat (5) @(negedge clock);
        chk("midrst_busy_before", busy_w[1], 1);
        #2 reset = 0;
        #1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("midrst_busy_%0d", j), busy_w[j], 0);
            chk($sformatf("midrst_done_%0d", j), done_w[j], 0);
            chk($sformatf("midrst_a_%0d", j), a_w[j], 0);
            chk($sformatf("midrst_b_%0d", j), b_w[j], 0);
        end
        @(negedge clock); reset = 1;
        run(16);
        verify("after_rst", 16, 0, 0, 1);

        count = 16;
        @(negedge clock); start = 1;
        @(negedge clock); start = 0;
        repeat (17) @(negedge clock);
        wr_en = 1; wr_addr = 0; wr_a = 0; wr_b = 0; wr_y = 8'hAA; start = 1;
        @(negedge clock); wr_en = 0; start = 0;
        for (n = 18; n < 80 && !done_w[2]; n++) @(negedge clock);
        chk("busy_ctl_done_cycle", n, 21);
        repeat (2) @(negedge clock);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("busy_ctl_norestart_%0d", j), busy_w[j], 0);
            chk($sformatf("busy_ctl_pass_%0d", j), pass_w[j], 1);
        end
        run(1);
        verify("entry0_kept", 1, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
endmodule
